// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared constants and types for the fetch-stage program counter.
//   PC_RESET_VEC  - default pcF after reset
//   PC_EXC_VEC    - default exception handler entry address
//   PC_IMEM_BASE  - lowest legal fetch address (inclusive)
//   PC_IMEM_END   - highest legal fetch address (inclusive)
//   pend_state_t  - state encoding of the stalled-redirect buffer
package pc_unit_pkg;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] PC_IMEM_BASE = 32'h0000_3000;
  localparam logic [31:0] PC_IMEM_END  = 32'h0000_6FFC;
  localparam int unsigned PC_INC       = 4;

  typedef enum logic {
    PEND_IDLE = 1'b0,
    PEND_HELD = 1'b1
  } pend_state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry buffer that remembers a branch/jump redirect
// which arrived while fetch was stalled, so it can be applied on the next
// enabled cycle.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   en            - fetch advance enable (0 = stall)
//   req, eretD    - exception entry / eret return; both discard the buffer
//   redir_valid   - redirect request this cycle
//   redir_target  - redirect target address
//   pend_valid    - buffer holds a redirect (state == PEND_HELD)
//   pend_target   - buffered redirect target
//   pend_state    - FSM state, exposed for observation
//
// Handshake: redir_valid is a single-cycle request with no ready; the
// redirect is either consumed this cycle (en=1) or captured here (en=0).
// A newer stalled redirect overwrites an older buffered one.
module pc_redirect_buf
  import pc_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             req,
  input  logic             eretD,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  output logic             pend_valid,
  output logic [WIDTH-1:0] pend_target,
  output pend_state_t      pend_state
);

  pend_state_t      state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PEND_IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (req || eretD) begin
      // Exception entry and eret make any buffered redirect stale.
      state_d = PEND_IDLE;
    end else if (en) begin
      // Enabled cycle: a fresh redirect or the buffered one is consumed by
      // the PC mux, so the buffer is empty afterwards either way.
      state_d = PEND_IDLE;
    end else if (redir_valid) begin
      state_d  = PEND_HELD;
      target_d = redir_target;
    end
  end

  assign pend_valid  = (state_q == PEND_HELD);
  assign pend_target = target_q;
  assign pend_state  = state_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter for the pipelined MIPS core.
// Next-PC priority: reset, exception entry (req), eret return (eretD),
// redirect (en & redir_valid), buffered redirect (en & pend_valid),
// sequential increment (en). With en=0 pcF holds and a redirect is buffered.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   en            - fetch advance enable (0 = stall)
//   req           - exception/interrupt request, jumps to EXC_VEC
//   eretD         - eret decoded, returns to epc
//   epc           - return address from CP0
//   redir_valid   - branch/jump redirect request
//   redir_target  - redirect target
//   pcF           - current fetch PC
//   pend_valid    - a stalled redirect is buffered
//   adelF         - pcF misaligned or outside [IMEM_BASE, IMEM_END]
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
  parameter int unsigned      INC       = PC_INC,
  parameter logic [WIDTH-1:0] IMEM_BASE = WIDTH'(PC_IMEM_BASE),
  parameter logic [WIDTH-1:0] IMEM_END  = WIDTH'(PC_IMEM_END)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             req,
  input  logic             eretD,
  input  logic [WIDTH-1:0] epc,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_target,
  output logic [WIDTH-1:0] pcF,
  output logic             pend_valid,
  output logic             adelF
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target;
  pend_state_t      pend_state;

  pc_redirect_buf #(
    .WIDTH(WIDTH)
  ) u_redirect_buf (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req         (req),
    .eretD       (eretD),
    .redir_valid (redir_valid),
    .redir_target(redir_target),
    .pend_valid  (pend_valid),
    .pend_target (pend_target),
    .pend_state  (pend_state)
  );

  always_comb begin
    pc_d = pc_q;
    if (req) begin
      pc_d = EXC_VEC;
    end else if (eretD) begin
      pc_d = epc;
    end else if (en) begin
      if (redir_valid) begin
        pc_d = redir_target;
      end else if (pend_valid) begin
        pc_d = pend_target;
      end else begin
        // Truncating add: wraps modulo 2^WIDTH.
        pc_d = pc_q + WIDTH'(INC);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pcF   = pc_q;
  assign adelF = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) || (pc_q > IMEM_END);

endmodule
